pueo_surf_trig_tx: RTL and testbench

SURF-side transmitter for the SURF→TURF trigger link. It frames trigger requests into the 16-bit, 4-clock-slot word stream that the TURF trigger receiver samples. Each trigger is two slots: a header word with bit 15 set, then a metadata word with bit 15 clear. Slot framing is locked to the 8-clock command phase, and a small FIFO absorbs bursts.

---
 rtl/pueo_surf_trig_tx.sv | 147 ++++++++++++++
 tb/tb_pueo_surf_trig_tx.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pueo_surf_trig_tx.sv
// SURF->TURF trigger link transmitter: queues trigger requests and frames them as
// header/metadata word pairs on 4-clock slots locked to the 8-clock command phase.
module pueo_surf_trig_tx #(
  parameter int FIFO_DEPTH = 4,
  parameter     SYSCLKTYPE = "NONE",
  parameter     DEBUG      = "FALSE"
) (
  input  logic        sysclk_i,
  input  logic        sysclk_rst_n_i,
  input  logic        sysclk_phase_i,
  input  logic        enable_i,
  input  logic [19:0] s_trig_tdata,
  input  logic        s_trig_tvalid,
  output logic        s_trig_tready,
  output logic [15:0] trig_dat_o,
  output logic        trig_dat_valid_o,
  output logic [15:0] trig_count_o,
  output logic        misalign_o,
  input  logic        misalign_clr_i
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FILL_ONE = 1;

  typedef enum logic [1:0] {ST_ALIGN, ST_IDLE, ST_HDR, ST_META} state_t;

  state_t        r_state;
  logic [19:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_fill;
  logic          r_up;
  logic [2:0]    r_slot_ctr;
  logic          r_phase;
  logic          r_misalign;
  logic [7:0]    r_meta;
  logic [15:0]   r_dat;
  logic          r_valid;
  logic [15:0]   r_trig_cnt;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_bnd;
  logic [19:0]   w_head;

  // Fill never exceeds the power-of-2 depth, so its MSB alone marks full.
  assign w_full  = r_fill[AW];
  assign w_empty = (r_fill == '0);
  assign w_push  = s_trig_tvalid & s_trig_tready;
  assign w_bnd   = r_phase | (r_slot_ctr == 3'd0) | (r_slot_ctr == 3'd4);
  assign w_pop   = w_bnd & enable_i & ~w_empty &
                   ((r_state == ST_IDLE) | (r_state == ST_META));
  assign w_head  = r_mem[r_rptr];

  assign s_trig_tready    = r_up & ~w_full;
  assign trig_dat_o       = r_dat;
  assign trig_dat_valid_o = r_valid;
  assign trig_count_o     = r_trig_cnt;
  assign misalign_o       = r_misalign;

  always_ff @(posedge sysclk_i) begin
    if (w_push) r_mem[r_wptr] <= s_trig_tdata;
  end

  always_ff @(posedge sysclk_i or negedge sysclk_rst_n_i) begin
    if (!sysclk_rst_n_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fill <= '0;
      r_up   <= 1'b0;
    end else begin
      r_up <= 1'b1;
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + FILL_ONE;
        2'b01:   r_fill <= r_fill - FILL_ONE;
        default: r_fill <= r_fill;
      endcase
    end
  end

  // A phase pulse that does not land where the counter expects it re-frames the slots.
  always_ff @(posedge sysclk_i or negedge sysclk_rst_n_i) begin
    if (!sysclk_rst_n_i) begin
      r_phase    <= 1'b0;
      r_slot_ctr <= 3'd0;
      r_misalign <= 1'b0;
    end else begin
      r_phase    <= sysclk_phase_i;
      r_slot_ctr <= r_phase ? 3'd1 : r_slot_ctr + 3'd1;
      if (sysclk_phase_i && (r_state != ST_ALIGN) && (r_slot_ctr != 3'd7))
        r_misalign <= 1'b1;
      else if (misalign_clr_i)
        r_misalign <= 1'b0;
    end
  end

  always_ff @(posedge sysclk_i or negedge sysclk_rst_n_i) begin
    if (!sysclk_rst_n_i) begin
      r_state    <= ST_ALIGN;
      r_meta     <= 8'h00;
      r_dat      <= 16'h0000;
      r_valid    <= 1'b0;
      r_trig_cnt <= 16'h0000;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_ALIGN: begin
          r_dat <= 16'h0000;
          if (sysclk_phase_i) r_state <= ST_IDLE;
        end
        ST_IDLE, ST_META: begin
          if (w_bnd) begin
            if (w_pop) begin
              r_dat      <= {4'h8, w_head[11:0]};
              r_meta     <= w_head[19:12];
              r_valid    <= 1'b1;
              r_trig_cnt <= r_trig_cnt + 16'd1;
              r_state    <= ST_HDR;
            end else begin
              r_dat   <= 16'h0000;
              r_state <= ST_IDLE;
            end
          end
        end
        ST_HDR: begin
          if (w_bnd) begin
            r_dat   <= {8'h00, r_meta};
            r_valid <= 1'b1;
            r_state <= ST_META;
          end
        end
        default: r_state <= ST_ALIGN;
      endcase
    end
  end

  generate
    if (DEBUG == "TRUE") begin : g_dbg
      (* mark_debug = "true" *) logic [17:0] r_dbg;
      always_ff @(posedge sysclk_i) r_dbg <= {r_state, r_dat};
    end
  endgenerate

endmodule

// File: tb/tb_pueo_surf_trig_tx.sv
// Self-checking bench for pueo_surf_trig_tx: randomized requests compared every
// clock against a slot-level reference model of the trigger link.
module tb_pueo_surf_trig_tx;
  localparam int DEPTH = 4;

  logic        sysclk_i = 1'b0;
  logic        sysclk_rst_n_i = 1'b0;
  logic        sysclk_phase_i = 1'b0;
  logic        enable_i = 1'b0;
  logic [19:0] s_trig_tdata = '0;
  logic        s_trig_tvalid = 1'b0;
  logic        s_trig_tready;
  logic [15:0] trig_dat_o;
  logic        trig_dat_valid_o;
  logic [15:0] trig_count_o;
  logic        misalign_o;
  logic        misalign_clr_i = 1'b0;

  always #5 sysclk_i = ~sysclk_i;

  pueo_surf_trig_tx #(.FIFO_DEPTH(DEPTH)) dut (
    .sysclk_i        (sysclk_i),
    .sysclk_rst_n_i  (sysclk_rst_n_i),
    .sysclk_phase_i  (sysclk_phase_i),
    .enable_i        (enable_i),
    .s_trig_tdata    (s_trig_tdata),
    .s_trig_tvalid   (s_trig_tvalid),
    .s_trig_tready   (s_trig_tready),
    .trig_dat_o      (trig_dat_o),
    .trig_dat_valid_o(trig_dat_valid_o),
    .trig_count_o    (trig_count_o),
    .misalign_o      (misalign_o),
    .misalign_clr_i  (misalign_clr_i)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int e        = 0;
  bit ph_en    = 0;
  int ph_next  = 0;

  // Reference model: slots are every 4 clocks counted from the clock after the latest phase.
  logic [19:0] q[$];
  bit          m_locked, m_up, m_owe, m_acc;
  int          m_last_ph;
  logic [7:0]  m_meta;
  logic [15:0] m_dat, m_cnt;
  logic        m_valid, m_mis;

  function automatic logic exp_rdy();
    return sysclk_rst_n_i && m_up && (q.size() < DEPTH);
  endfunction

  task automatic model_reset();
    q.delete();
    m_locked = 0; m_up = 0; m_owe = 0; m_acc = 0; m_last_ph = 0;
    m_meta = '0; m_dat = '0; m_cnt = '0; m_valid = 1'b0; m_mis = 1'b0;
  endtask

  task automatic tick();
    logic [19:0] head;
    bit bnd;
    sysclk_phase_i = ph_en && (e + 1 == ph_next);
    if (sysclk_phase_i) ph_next += 8;
    @(posedge sysclk_i);
    e++;
    m_acc = 0;
    if (sysclk_rst_n_i) begin
      m_acc = s_trig_tvalid && m_up && (q.size() < DEPTH);
      bnd = m_locked && ((e - m_last_ph - 1) % 4 == 0);
      if (sysclk_phase_i && m_locked && ((e - m_last_ph) % 8 != 0)) m_mis = 1'b1;
      else if (misalign_clr_i) m_mis = 1'b0;
      m_valid = 1'b0;
      if (bnd) begin
        if (m_owe) begin
          m_dat = {8'h00, m_meta}; m_valid = 1'b1; m_owe = 0;
        end else if (enable_i && q.size() > 0) begin
          head = q.pop_front();
          m_dat = {4'h8, head[11:0]}; m_meta = head[19:12];
          m_valid = 1'b1; m_owe = 1; m_cnt = m_cnt + 16'd1;
        end else begin
          m_dat = 16'h0000;
        end
      end
      if (m_acc) q.push_back(s_trig_tdata);
      if (sysclk_phase_i) begin m_locked = 1; m_last_ph = e; end
      m_up = 1;
    end
    #1;
  endtask

  task automatic test_reset();
    sysclk_rst_n_i = 1'b0; ph_en = 0; enable_i = 1'b0; s_trig_tvalid = 1'b0;
    model_reset();
    repeat (3) tick();
    n_checks++;
    if ({trig_dat_o, trig_dat_valid_o, trig_count_o, misalign_o, s_trig_tready} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_state dat=%h v=%b cnt=%h mis=%b rdy=%b want all zero",
               trig_dat_o, trig_dat_valid_o, trig_count_o, misalign_o, s_trig_tready);
    end
    @(negedge sysclk_i);
    sysclk_rst_n_i = 1'b1;
    tick();
    n_checks++;
    if ({trig_dat_o, trig_dat_valid_o, trig_count_o, misalign_o, s_trig_tready} !==
        {m_dat, m_valid, m_cnt, m_mis, exp_rdy()}) begin
      n_fail++;
      $display("FAIL reset_release e=%0d got %h_%b_%h_%b_%b want %h_%b_%h_%b_%b", e,
               trig_dat_o, trig_dat_valid_o, trig_count_o, misalign_o, s_trig_tready,
               m_dat, m_valid, m_cnt, m_mis, exp_rdy());
    end
  endtask

  task automatic test_idle();
    ph_en = 1; ph_next = e + 3;
    repeat (40) begin
      tick();
      n_checks++;
      if ({trig_dat_o, trig_dat_valid_o, trig_count_o, misalign_o, s_trig_tready} !==
          {m_dat, m_valid, m_cnt, m_mis, exp_rdy()}) begin
        n_fail++;
        $display("FAIL idle e=%0d got %h_%b_%h_%b_%b want %h_%b_%h_%b_%b", e,
                 trig_dat_o, trig_dat_valid_o, trig_count_o, misalign_o, s_trig_tready,
                 m_dat, m_valid, m_cnt, m_mis, exp_rdy());
      end
    end
  endtask

  task automatic test_single();
    int guard;
    int strobes;
    logic [15:0] c0;
    enable_i = 1'b1;
    guard = 0;
    while (!(m_locked && ((e + 4 - m_last_ph - 1) % 4 == 0)) && guard < 20) begin
      tick(); guard++;
    end
    n_checks++;
    if (guard >= 20) begin n_fail++; $display("FAIL single_sync timeout e=%0d", e); end
    c0 = m_cnt;
    s_trig_tvalid = 1'b1; s_trig_tdata = {8'h5A, 12'hABC};
    tick();
    s_trig_tvalid = 1'b0;
    strobes = 0;
    repeat (16) begin
      tick();
      if (trig_dat_valid_o) begin
        if (strobes == 0) begin
          n_checks++;
          if (trig_dat_o !== 16'h8ABC) begin
            n_fail++; $display("FAIL single_hdr got %h want 8abc", trig_dat_o);
          end
        end
        strobes++;
      end
      n_checks++;
      if ({trig_dat_o, trig_dat_valid_o, trig_count_o, misalign_o, s_trig_tready} !==
          {m_dat, m_valid, m_cnt, m_mis, exp_rdy()}) begin
        n_fail++;
        $display("FAIL single e=%0d got %h_%b_%h_%b_%b want %h_%b_%h_%b_%b", e,
                 trig_dat_o, trig_dat_valid_o, trig_count_o, misalign_o, s_trig_tready,
                 m_dat, m_valid, m_cnt, m_mis, exp_rdy());
      end
    end
    n_checks++;
    if (strobes != 2 || trig_count_o !== c0 + 16'd1) begin
      n_fail++;
      $display("FAIL single_count strobes=%0d cnt=%h want strobes=2 cnt=%h", strobes, trig_count_o, c0 + 16'd1);
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] items[6];
    int pushed, hdr_i, cyc;
    logic [15:0] c0;
    for (int i = 0; i < 6; i++) items[i] = 20'($urandom);
    pushed = 0; hdr_i = 0; cyc = 0; c0 = m_cnt;
    enable_i = 1'b1;
    while ((pushed < 6 || q.size() > 0 || m_owe) && cyc < 200) begin
      s_trig_tvalid = (pushed < 6);
      s_trig_tdata  = items[(pushed < 6) ? pushed : 0];
      tick();
      if (m_acc) pushed++;
      cyc++;
      if (trig_dat_valid_o && trig_dat_o[15]) begin
        n_checks++;
        if (hdr_i > 5 || trig_dat_o[11:0] !== items[(hdr_i > 5) ? 0 : hdr_i][11:0]) begin
          n_fail++; $display("FAIL b2b_order idx=%0d got %h", hdr_i, trig_dat_o[11:0]);
        end
        hdr_i++;
      end
      n_checks++;
      if ({trig_dat_o, trig_dat_valid_o, trig_count_o, misalign_o, s_trig_tready} !==
          {m_dat, m_valid, m_cnt, m_mis, exp_rdy()}) begin
        n_fail++;
        $display("FAIL b2b e=%0d got %h_%b_%h_%b_%b want %h_%b_%h_%b_%b", e,
                 trig_dat_o, trig_dat_valid_o, trig_count_o, misalign_o, s_trig_tready,
                 m_dat, m_valid, m_cnt, m_mis, exp_rdy());
      end
    end
    s_trig_tvalid = 1'b0;
    repeat (6) tick();
    n_checks++;
    if (cyc >= 200 || trig_count_o !== c0 + 16'd6 || hdr_i != 6) begin
      n_fail++;
      $display("FAIL b2b_total cyc=%0d hdrs=%0d cnt=%h want hdrs=6 cnt=%h", cyc, hdr_i, trig_count_o, c0 + 16'd6);
    end
  endtask

  task automatic test_misalign();
    repeat (8) tick();
    ph_next += 2;
    s_trig_tvalid = 1'b1; s_trig_tdata = 20'($urandom);
    repeat (24) begin
      tick();
      if (m_acc) s_trig_tvalid = 1'b0;
      n_checks++;
      if ({trig_dat_o, trig_dat_valid_o, trig_count_o, misalign_o, s_trig_tready} !==
          {m_dat, m_valid, m_cnt, m_mis, exp_rdy()}) begin
        n_fail++;
        $display("FAIL misalign e=%0d got %h_%b_%h_%b_%b want %h_%b_%h_%b_%b", e,
                 trig_dat_o, trig_dat_valid_o, trig_count_o, misalign_o, s_trig_tready,
                 m_dat, m_valid, m_cnt, m_mis, exp_rdy());
      end
    end
    s_trig_tvalid = 1'b0;
    n_checks++;
    if (misalign_o !== 1'b1) begin n_fail++; $display("FAIL misalign_set got %b want 1", misalign_o); end
    ph_next += 2;
    for (int i = 0; i < 12; i++) begin
      misalign_clr_i = (e + 1 == ph_next);
      tick();
      if (misalign_clr_i) begin
        misalign_clr_i = 1'b0;
        n_checks++;
        if (misalign_o !== 1'b1) begin n_fail++; $display("FAIL misalign_priority got %b want 1", misalign_o); end
      end
    end
    misalign_clr_i = 1'b1;
    tick();
    misalign_clr_i = 1'b0;
    n_checks++;
    if (misalign_o !== m_mis || misalign_o !== 1'b0) begin
      n_fail++; $display("FAIL misalign_clear got %b want 0", misalign_o);
    end
  endtask

  task automatic test_enable();
    int pushed, guard;
    logic [15:0] c0;
    enable_i = 1'b0; c0 = m_cnt; pushed = 0; guard = 0;
    while (pushed < 3 && guard < 20) begin
      s_trig_tvalid = 1'b1; s_trig_tdata = 20'($urandom);
      tick();
      if (m_acc) pushed++;
      guard++;
    end
    s_trig_tvalid = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (i == 24) enable_i = 1'b1;
      if (i == 60) enable_i = 1'b1;
      tick();
      if (i >= 24 && i < 60 && m_valid && m_owe && m_cnt == c0 + 16'd2) enable_i = 1'b0;
      if (i == 23) begin
        n_checks++;
        if (trig_count_o !== c0) begin n_fail++; $display("FAIL enable_hold cnt=%h want %h", trig_count_o, c0); end
      end
      if (i == 59) begin
        n_checks++;
        if (trig_count_o !== c0 + 16'd2 || trig_dat_o !== 16'h0000) begin
          n_fail++; $display("FAIL enable_drop cnt=%h dat=%h want cnt=%h dat=0000", trig_count_o, trig_dat_o, c0 + 16'd2);
        end
      end
      n_checks++;
      if ({trig_dat_o, trig_dat_valid_o, trig_count_o, misalign_o, s_trig_tready} !==
          {m_dat, m_valid, m_cnt, m_mis, exp_rdy()}) begin
        n_fail++;
        $display("FAIL enable e=%0d got %h_%b_%h_%b_%b want %h_%b_%h_%b_%b", e,
                 trig_dat_o, trig_dat_valid_o, trig_count_o, misalign_o, s_trig_tready,
                 m_dat, m_valid, m_cnt, m_mis, exp_rdy());
      end
    end
    n_checks++;
    if (trig_count_o !== c0 + 16'd3) begin n_fail++; $display("FAIL enable_drain cnt=%h want %h", trig_count_o, c0 + 16'd3); end
  endtask

  task automatic test_random();
    enable_i = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) enable_i = ($urandom_range(0, 3) != 0);
      s_trig_tvalid = ($urandom_range(0, 2) == 0);
      s_trig_tdata  = 20'($urandom);
      tick();
      n_checks++;
      if ({trig_dat_o, trig_dat_valid_o, trig_count_o, misalign_o, s_trig_tready} !==
          {m_dat, m_valid, m_cnt, m_mis, exp_rdy()}) begin
        n_fail++;
        $display("FAIL random e=%0d got %h_%b_%h_%b_%b want %h_%b_%h_%b_%b", e,
                 trig_dat_o, trig_dat_valid_o, trig_count_o, misalign_o, s_trig_tready,
                 m_dat, m_valid, m_cnt, m_mis, exp_rdy());
      end
    end
    s_trig_tvalid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int guard;
    enable_i = 1'b1; guard = 0;
    s_trig_tvalid = 1'b1; s_trig_tdata = 20'($urandom);
    while (!m_owe && guard < 40) begin
      tick();
      if (m_acc) s_trig_tvalid = 1'b0;
      guard++;
    end
    s_trig_tvalid = 1'b0;
    n_checks++;
    if (guard >= 40) begin n_fail++; $display("FAIL rstmid_hdr timeout e=%0d", e); end
    #2;
    sysclk_rst_n_i = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({trig_dat_o, trig_dat_valid_o, trig_count_o, misalign_o, s_trig_tready} !== 35'd0) begin
      n_fail++;
      $display("FAIL rstmid_async dat=%h v=%b cnt=%h mis=%b rdy=%b want all zero",
               trig_dat_o, trig_dat_valid_o, trig_count_o, misalign_o, s_trig_tready);
    end
    ph_en = 0;
    @(negedge sysclk_i);
    sysclk_rst_n_i = 1'b1;
    s_trig_tvalid = 1'b1; s_trig_tdata = {8'hC3, 12'h123};
    for (int i = 0; i < 50; i++) begin
      if (i == 20) begin ph_en = 1; ph_next = e + 5; end
      tick();
      if (m_acc) s_trig_tvalid = 1'b0;
      n_checks++;
      if ({trig_dat_o, trig_dat_valid_o, trig_count_o, misalign_o, s_trig_tready} !==
          {m_dat, m_valid, m_cnt, m_mis, exp_rdy()}) begin
        n_fail++;
        $display("FAIL rstmid e=%0d got %h_%b_%h_%b_%b want %h_%b_%h_%b_%b", e,
                 trig_dat_o, trig_dat_valid_o, trig_count_o, misalign_o, s_trig_tready,
                 m_dat, m_valid, m_cnt, m_mis, exp_rdy());
      end
    end
    s_trig_tvalid = 1'b0;
    n_checks++;
    if (trig_count_o !== 16'd1) begin n_fail++; $display("FAIL rstmid_relock cnt=%h want 0001", trig_count_o); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_idle();
    test_single();
    test_back_to_back();
    test_misalign();
    test_enable();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at e=%0d", e);
    $fatal(1);
  end

endmodule
